// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive paths of the host link.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int UART_FRAME_BITS = 10;
    localparam int UART_DATA_BITS  = 8;

    // Clock cycles per line bit; integer division matches the receiver's sampling grid.
    function automatic int unsigned baud_cnt_max(input int unsigned clk_freq,
                                                 input int unsigned bps);
        return clk_freq / bps;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 serializer: baud counter, bit counter and START/DATA/STOP sequencing.
// Chains straight into another frame with no gap when the caller has more bytes queued.
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int unsigned UART_BPS = 9600,
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic       clk_50m,
    input  logic       sys_rst_n,
    input  logic       start,
    input  logic       more,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic       byte_done,
    output logic       frame_end
);

    localparam int unsigned BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
    localparam logic [15:0] BAUD_LAST    = 16'(BAUD_CNT_MAX - 1);

    generate
        if (BAUD_CNT_MAX < 1 || BAUD_CNT_MAX > 65535) begin : g_baud_range_check
            $error("uart_tx_byte: BAUD_CNT_MAX %0d does not fit the 16-bit baud counter",
                   BAUD_CNT_MAX);
        end
    endgenerate

    uart_state_e state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [2:0]  bit_nxt;
    logic        baud_end;

    assign baud_end  = (baud_cnt == BAUD_LAST);
    assign bit_nxt   = bit_cnt + 3'd1;
    assign frame_end = (state == STOP) && baud_end;

    // The counter is held at zero while idle so every frame starts on a fresh bit period.
    always_ff @(posedge clk_50m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            baud_cnt <= 16'd0;
        end else if (state == IDLE || baud_end) begin
            baud_cnt <= 16'd0;
        end else begin
            baud_cnt <= baud_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk_50m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            tx        <= 1'b1;
            byte_done <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            case (state)
                IDLE: begin
                    bit_cnt <= 3'd0;
                    tx      <= 1'b1;
                    if (start) begin
                        state <= START;
                        tx    <= 1'b0;
                    end
                end
                START: begin
                    if (baud_end) begin
                        state   <= DATA;
                        bit_cnt <= 3'd0;
                        tx      <= data_in[0];
                    end
                end
                // tx is registered, so each boundary loads the bit for the period that follows.
                DATA: begin
                    if (baud_end) begin
                        if (bit_cnt == 3'd7) begin
                            state   <= STOP;
                            bit_cnt <= 3'd0;
                            tx      <= 1'b1;
                        end else begin
                            bit_cnt <= bit_nxt;
                            tx      <= data_in[bit_nxt];
                        end
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        byte_done <= 1'b1;
                        if (more) begin
                            state <= START;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_pix_tx.sv
// Sends a 24-bit pixel word as three 8N1 bytes, high byte first, so the receiver's
// byte assembler rebuilds the same word on loopback.
module uart_pix_tx
    import uart_pkg::*;
#(
    parameter int unsigned UART_BPS = 9600,
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic        clk_50m,
    input  logic        sys_rst_n,
    input  logic [23:0] pi_data,
    input  logic        pi_valid,
    output logic        pi_ready,
    output logic        tx,
    output logic        busy,
    output logic        byte_done
);

    logic [23:0] shreg;
    logic [1:0]  byte_cnt;
    logic        accept;
    logic        more;
    logic        frame_end;

    assign accept = pi_valid && pi_ready;
    assign more   = (byte_cnt != 2'd2);

    // pi_ready and busy flip on the same edge the serializer leaves or re-enters IDLE.
    always_ff @(posedge clk_50m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            shreg    <= 24'd0;
            byte_cnt <= 2'd0;
            pi_ready <= 1'b1;
            busy     <= 1'b0;
        end else if (accept) begin
            shreg    <= pi_data;
            byte_cnt <= 2'd0;
            pi_ready <= 1'b0;
            busy     <= 1'b1;
        end else if (frame_end) begin
            shreg <= {shreg[15:0], 8'h00};
            if (more) begin
                byte_cnt <= byte_cnt + 2'd1;
            end else begin
                byte_cnt <= 2'd0;
                pi_ready <= 1'b1;
                busy     <= 1'b0;
            end
        end
    end

    uart_tx_byte #(
        .UART_BPS (UART_BPS),
        .CLK_FREQ (CLK_FREQ)
    ) u_tx_byte (
        .clk_50m   (clk_50m),
        .sys_rst_n (sys_rst_n),
        .start     (accept),
        .more      (more),
        .data_in   (shreg[23:16]),
        .tx        (tx),
        .byte_done (byte_done),
        .frame_end (frame_end)
    );

endmodule

// File: tb/tb_uart_pix_tx.sv
// Scoreboard bench for uart_pix_tx at N=10: a line receiver, a handshake monitor and
// directed stimulus that queues the expected words, acceptance edges and byte_done edges.
module tb_uart_pix_tx;

    localparam int unsigned CLK_FREQ = 100;
    localparam int unsigned UART_BPS = 10;
    localparam int N = 10;
    localparam int WORD_CYCLES = 30 * N;

    logic        clk_50m = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [23:0] pi_data = 24'd0;
    logic        pi_valid = 1'b0;
    logic        pi_ready;
    logic        tx;
    logic        busy;
    logic        byte_done;

    typedef struct {
        int cyc;
        bit last;
    } done_t;

    logic [23:0] exp_word_q[$];
    int          exp_acc_q[$];
    done_t       exp_done_q[$];

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    uart_pix_tx #(
        .UART_BPS (UART_BPS),
        .CLK_FREQ (CLK_FREQ)
    ) dut (
        .clk_50m   (clk_50m),
        .sys_rst_n (sys_rst_n),
        .pi_data   (pi_data),
        .pi_valid  (pi_valid),
        .pi_ready  (pi_ready),
        .tx        (tx),
        .busy      (busy),
        .byte_done (byte_done)
    );

    always #5 clk_50m = ~clk_50m;

    always @(posedge clk_50m) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic push_expect(input logic [23:0] word, input int k);
        done_t d;
        exp_word_q.push_back(word);
        exp_acc_q.push_back(k);
        for (int b = 1; b <= 3; b++) begin
            d.cyc  = k + b * 10 * N;
            d.last = (b == 3);
            exp_done_q.push_back(d);
        end
    endtask

    task automatic rx_wait(input int n, output bit alive);
        alive = 1'b1;
        repeat (n) begin
            @(negedge clk_50m);
            if (!sys_rst_n) begin
                alive = 1'b0;
                return;
            end
        end
    endtask

    task automatic advance_to(input int target);
        while (cyc < target) begin
            @(posedge clk_50m);
            #1;
        end
    endtask

    // Offers one word for a single cycle; k is the acceptance edge.
    task automatic applyStimulus(input logic [23:0] word, output int k);
        int w;
        w = 0;
        while (!pi_ready && w < 2000) begin
            @(posedge clk_50m);
            #1;
            w++;
        end
        checkOutput("ready_before_send", pi_ready, 1'b1);
        pi_data  = word;
        pi_valid = 1'b1;
        k = cyc + 1;
        push_expect(word, k);
        @(posedge clk_50m);
        #1;
        pi_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while ((exp_done_q.size() > 0 || !pi_ready) && w < 2 * WORD_CYCLES) begin
            @(posedge clk_50m);
            #1;
            w++;
        end
        checkOutput("idle_reached", (exp_done_q.size() == 0) && pi_ready, 1'b1);
    endtask

    // Line receiver: samples mid-bit and assembles bytes in arrival order.
    initial begin : rx_monitor
        logic [7:0]  rx_byte;
        logic [23:0] rx_word;
        int          rx_idx;
        bit          alive;
        rx_idx  = 0;
        rx_byte = 8'd0;
        rx_word = 24'd0;
        forever begin
            @(negedge clk_50m);
            if (!sys_rst_n) begin
                rx_idx = 0;
            end else if (tx === 1'b0) begin
                rx_wait(4, alive);
                if (alive) checkOutput("rx_start_bit", tx, 1'b0);
                for (int b = 0; b < 8 && alive; b++) begin
                    rx_wait(10, alive);
                    rx_byte[b] = tx;
                end
                if (alive) rx_wait(10, alive);
                if (!alive) begin
                    rx_idx = 0;
                end else begin
                    checkOutput("rx_stop_bit", tx, 1'b1);
                    rx_word = {rx_word[15:0], rx_byte};
                    rx_idx++;
                    if (rx_idx == 3) begin
                        rx_idx = 0;
                        checkOutput("word_expected", exp_word_q.size() > 0, 1'b1);
                        if (exp_word_q.size() > 0)
                            checkOutput("rx_word", rx_word, exp_word_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin : handshake_monitor
        done_t d;
        forever begin
            @(negedge clk_50m);
            if (sys_rst_n) begin
                if (pi_valid && pi_ready) begin
                    checkOutput("accept_expected", exp_acc_q.size() > 0, 1'b1);
                    if (exp_acc_q.size() > 0)
                        checkOutput("accept_cycle", cyc + 1, exp_acc_q.pop_front());
                end
                if (byte_done) begin
                    checkOutput("done_expected", exp_done_q.size() > 0, 1'b1);
                    if (exp_done_q.size() > 0) begin
                        d = exp_done_q.pop_front();
                        checkOutput("byte_done_cycle", cyc, d.cyc);
                        checkOutput("ready_at_done", pi_ready, d.last);
                        checkOutput("busy_at_done", busy, !d.last);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got cycle %0d expected under 20000", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int k;
        logic [9:0] pat;

        // Reset values, during and after reset.
        sys_rst_n = 1'b0;
        repeat (3) @(posedge clk_50m);
        #1;
        checkOutput("rst_tx", tx, 1'b1);
        checkOutput("rst_ready", pi_ready, 1'b1);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", byte_done, 1'b0);
        sys_rst_n = 1'b1;
        repeat (5) @(posedge clk_50m);
        #1;
        checkOutput("post_rst_tx", tx, 1'b1);
        checkOutput("post_rst_ready", pi_ready, 1'b1);
        checkOutput("post_rst_busy", busy, 1'b0);
        checkOutput("post_rst_done", byte_done, 1'b0);

        // Single word, with the first frame checked mid-bit against a hand-derived pattern.
        $display("[TB] single word A53C0F");
        pat = 10'b1101001010;
        applyStimulus(24'hA53C0F, k);
        checkOutput("accept_busy", busy, 1'b1);
        for (int i = 0; i < 10; i++) begin
            advance_to(k + 10 * i + 5);
            checkOutput("byte1_bit", tx, pat[i]);
        end
        wait_idle();

        $display("[TB] loopback 123456");
        applyStimulus(24'h123456, k);
        wait_idle();

        // Requests while busy must be ignored.
        $display("[TB] ignored request");
        applyStimulus(24'hA53C0F, k);
        advance_to(k + 150);
        checkOutput("ready_while_busy", pi_ready, 1'b0);
        pi_data  = 24'hFFFFFF;
        pi_valid = 1'b1;
        @(posedge clk_50m);
        #1;
        pi_valid = 1'b0;
        advance_to(k + 250);
        pi_valid = 1'b1;
        @(posedge clk_50m);
        #1;
        pi_valid = 1'b0;
        wait_idle();

        // Reset during bit 3 of the second byte (a zero bit), then a clean word.
        $display("[TB] reset mid-word");
        applyStimulus(24'h5A00C3, k);
        advance_to(k + 145);
        checkOutput("tx_before_reset", tx, 1'b0);
        #2;
        sys_rst_n = 1'b0;
        exp_word_q.delete();
        exp_acc_q.delete();
        exp_done_q.delete();
        #1;
        checkOutput("async_rst_tx", tx, 1'b1);
        checkOutput("async_rst_ready", pi_ready, 1'b1);
        checkOutput("async_rst_busy", busy, 1'b0);
        repeat (5) @(posedge clk_50m);
        #1;
        sys_rst_n = 1'b1;
        @(posedge clk_50m);
        #1;
        checkOutput("release_ready", pi_ready, 1'b1);
        checkOutput("release_tx", tx, 1'b1);
        applyStimulus(24'h00FF00, k);
        wait_idle();

        // Back-to-back with pi_valid held: one idle cycle between words.
        $display("[TB] back-to-back");
        pi_data  = 24'h111111;
        pi_valid = 1'b1;
        k = cyc + 1;
        push_expect(24'h111111, k);
        push_expect(24'h222222, k + WORD_CYCLES + 1);
        @(posedge clk_50m);
        #1;
        pi_data = 24'h222222;
        advance_to(k + WORD_CYCLES);
        checkOutput("gap_tx", tx, 1'b1);
        checkOutput("gap_ready", pi_ready, 1'b1);
        advance_to(k + WORD_CYCLES + 1);
        checkOutput("second_start_tx", tx, 1'b0);
        checkOutput("second_ready", pi_ready, 1'b0);
        pi_valid = 1'b0;
        advance_to(k + 2 * WORD_CYCLES + 1);
        checkOutput("b2b_total_ready", pi_ready, 1'b1);
        wait_idle();

        repeat (5) @(posedge clk_50m);
        #1;
        checkOutput("pending_words", exp_word_q.size(), 0);
        checkOutput("pending_accepts", exp_acc_q.size(), 0);
        checkOutput("pending_done", exp_done_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
